// File: rtl/nibble_add_sequencer_pkg.sv
// rtl/nibble_add_sequencer_pkg.sv - shared types and constants for the nibble add sequencer
// Contents: SLICE_W (slice width in bits), state_t (sequencer FSM states).
package nibble_add_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add_sequencer_if.sv
// rtl/nibble_add_sequencer_if.sv - operand/result handshake bundle for the nibble add sequencer
// Signals: in_valid/in_ready/a/b/cin (operand side), out_valid/out_ready/sum/cout/ovf (result side), busy.
// Optional: op_sub when NIBBLE_ADD_SEQUENCER_SUB_EN is defined.
// Modports: master = operand source / result consumer, slave = the sequencer.
interface nibble_add_sequencer_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
`ifdef NIBBLE_ADD_SEQUENCER_SUB_EN
  logic             op_sub;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
`endif

endinterface

// File: rtl/nibble_add_sequencer_slice.sv
// rtl/nibble_add_sequencer_slice.sv - combinational 4-bit ripple-carry adder slice
// Ports: a[3:0], b[3:0], cin in; sum[3:0], cout out.
module nibble_adder_slice
  import nibble_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - multi-cycle WIDTH-bit adder using one shared 4-bit slice, LSB first
// Ports: clk, rst_n (synchronous, active-low), bus (nibble_add_sequencer_if.slave).
// Optional subtract mode: define NIBBLE_ADD_SEQUENCER_SUB_EN to enable bus.op_sub.
module nibble_add_sequencer
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_add_sequencer_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already holds b_eff (inverted in subtract mode)
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] b_eff_in;
  logic             cin_eff_in;

`ifdef NIBBLE_ADD_SEQUENCER_SUB_EN
  // Subtract as a + ~b + 1; the forced carry-in supplies the +1.
  assign b_eff_in   = bus.op_sub ? ~bus.b : bus.b;
  assign cin_eff_in = bus.op_sub | bus.cin;
`else
  assign b_eff_in   = bus.b;
  assign cin_eff_in = bus.cin;
`endif

  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;

  assign s_a = a_q[int'(idx) * SLICE_W +: SLICE_W];
  assign s_b = b_q[int'(idx) * SLICE_W +: SLICE_W];

  nibble_adder_slice u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= b_eff_in;
            carry_q    <= cin_eff_in;
            idx        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_q[int'(idx) * SLICE_W +: SLICE_W] <= s_sum;
          carry_q <= s_cout;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout_q      <= s_cout;
            // Signed overflow: operands agree in sign but the new MSB does not.
            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (s_sum[SLICE_W-1] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - directed self-checking bench for nibble_add_sequencer
module tb_nibble_add_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  nibble_add_sequencer_if #(.WIDTH(16)) bus ();

  nibble_add_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits (at negedges) until out_valid, returns edges waited; bounded.
  task automatic wait_result(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("result_timeout", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic [15:0] es, input logic ec, input logic eo);
    int n;
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = cv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 16'hDEAD;
    bus.b        = 16'hBEEF;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    wait_result(n);
    chk({tag, "_latency"}, n, 32'd4);
    chk({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_drained"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef NIBBLE_ADD_SEQUENCER_SUB_EN
    bus.op_sub    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_sum", {16'd0, bus.sum}, 32'd0);
    chk("rst_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);

    do_op("add1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("ovf", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);

    // Backpressure with in_valid held; operands change after acceptance.
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.a = 16'hAAAA;
    wait_result(n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_sum", {16'd0, bus.sum}, 32'h3333);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("bp_sum_final", {15'd0, bus.sum, bus.cout}, {15'd0, 16'h3333, 1'b0});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_idle", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_second_accept", {30'd0, bus.busy, bus.in_ready}, 32'b10);
    wait_result(n);
    chk("bp_second_sum", {16'd0, bus.sum}, 32'hCCCC);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset while idx==2.
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_sum", {16'd0, bus.sum}, 32'd0);
    chk("midrst_flags", {29'd0, bus.out_valid, bus.busy, bus.in_ready}, 32'b001);
    @(negedge clk);
    chk("midrst_no_result", {31'd0, bus.out_valid}, 32'd0);
    do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

`ifdef NIBBLE_ADD_SEQUENCER_SUB_EN
    bus.op_sub = 1'b1;
    do_op("sub1", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub2", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    bus.op_sub = 1'b0;
    do_op("add_after_sub", 16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_add_sequencer.md
Name: nibble_add_sequencer

Overview:
- Multi-cycle wide adder. Adds two WIDTH-bit operands one 4-bit slice per cycle, LSB slice first, through a single shared 4-bit ripple slice.
- A registered carry links each slice to the next.
- Valid/ready handshake on input and output. Sits between an operand source and a result consumer where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NSLICE, WIDTH/4, derived slice count; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands a, b, cin presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to slice 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, registered
- cout  output  1  carry out of MSB slice, registered
- ovf  output  1  two's-complement signed overflow, registered
- busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. While rst_n=0, all inputs are ignored.
- Reset values:
  - state=IDLE, slice index=0, carry reg=0.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0.
  - in_ready=1 on the first cycle after reset.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b, cin; idx<=0; carry<=cin; go to RUN.
- FSM RUN:
  - in_ready=0, busy=1.
  - Each cycle the slice adds a[4*idx+:4] + b[4*idx+:4] + carry. Result nibble is written to sum[4*idx+:4]; carry<=slice carry-out; idx<=idx+1.
  - When idx==NSLICE-1, that write completes the operation: cout<=slice carry-out; ovf<=(a[MSB]==b_eff[MSB]) && (new sum[MSB]!=a[MSB]); go to DONE.
- FSM DONE:
  - out_valid=1; sum, cout, ovf held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready=0 throughout DONE, so in_valid during DONE is not accepted.
- Latency and throughput:
  - out_valid rises exactly NSLICE cycles after the accepting edge (4 for WIDTH=16).
  - Minimum issue period is NSLICE+2 cycles.
- sum is only defined when out_valid=1; partial nibbles are visible during RUN.
- Operand capture registers are unaffected by input changes after acceptance.
- Wrap-around: the final carry is reported on cout only and never wraps into sum.
- Reset mid-RUN or mid-DONE: the next cycle shows reset values; the pending result is discarded with no output handshake.
- out_ready asserted outside DONE is ignored.

Optional Feature:
- Macro: NIBBLE_ADD_SEQUENCER_SUB_EN.
- Defined:
  - Adds port op_sub (input, 1), captured with the operands.
  - op_sub=1: b_eff=~b, and slice-0 carry-in is forced to 1 (cin ignored). cout=1 means no borrow. ovf uses b_eff.
  - op_sub=0: identical to the undefined case.
- Undefined: no op_sub port; b_eff=b.

Decomposition:
- Package nibble_add_pkg:
  - localparam SLICE_W=4.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t.
- Sub-module nibble_adder_slice:
  - Combinational 4-bit ripple adder.
  - Inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout.
  - Instantiated once; all sequencing lives in the parent.

Test Plan:
- 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples across all 4 slice cycles).
- 0x7FFF+0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 held -> out_valid=1, sum/cout/ovf stable, in_ready=0, no second capture. Then out_ready=1 -> IDLE next cycle; new operation accepted the following cycle.
- Reset mid-operation: rst_n=0 for 1 cycle while idx=2 -> next cycle sum=0, out_valid=0, busy=0, in_ready=1. A following 0x00FF+0x0001 -> sum=0x0100, cout=0.
- With NIBBLE_ADD_SEQUENCER_SUB_EN: 0x0005-0x0007, op_sub=1 -> sum=0xFFFE, cout=0, ovf=0. 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
